bcd_down_counter: RTL

Loadable multi-digit BCD countdown timer: the decrementing counterpart to the team's BCD up-counters. It holds a packed BCD value and counts it down one step per clock-enable tick, borrowing across digits. It pulses `done` when the count expires, and either stops or auto-reloads. It sits beside the up-counters as the timeout/interval source for display and timing logic, and shares their packed-digit data format.

---
 rtl/bcd_down_counter.sv | 111 +++++++++++
 1 files changed

// File: rtl/bcd_down_counter.sv
// Loadable packed-BCD countdown timer with one-shot or periodic expiry.
// Decrements once per ce tick in RUN; pulses done on expiry.
module bcd_down_counter #(
    parameter int PARAM_DIGITS      = 4,
    parameter int PARAM_BASE        = 10,
    parameter bit PARAM_AUTO_RELOAD = 1'b0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      ce,
    input  logic                      load,
    input  logic [4*PARAM_DIGITS-1:0] load_data,
    input  logic                      start,
    input  logic                      stop,
    output logic [4*PARAM_DIGITS-1:0] data,
    output logic                      running,
    output logic                      done,
    output logic                      load_err
);

    localparam int         LP_W    = 4 * PARAM_DIGITS;
    localparam logic [4:0] LP_BASE = 5'(PARAM_BASE);
    localparam logic [3:0] LP_MAX  = 4'(PARAM_BASE - 1);

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } state_t;

    state_t          r_state;
    logic [LP_W-1:0] r_data;
    logic [LP_W-1:0] r_rl;
    logic            r_done;
    logic            r_load_err;

    logic [LP_W-1:0] w_dec;
    logic            w_valid;
    logic            w_zero;
    logic            w_one;
    logic [PARAM_DIGITS:0] w_low_zero;

    // A digit steps only when every less-significant digit is already 0.
    always_comb begin
        w_dec      = r_data;
        w_valid    = 1'b1;
        w_low_zero = '0;
        w_low_zero[0] = 1'b1;
        for (int i = 0; i < PARAM_DIGITS; i++) begin
            w_low_zero[i+1] = w_low_zero[i] & (r_data[4*i +: 4] == 4'd0);
            if (w_low_zero[i]) begin
                if (r_data[4*i +: 4] == 4'd0)
                    w_dec[4*i +: 4] = LP_MAX;
                else
                    w_dec[4*i +: 4] = r_data[4*i +: 4] - 4'd1;
            end
            if ({1'b0, load_data[4*i +: 4]} >= LP_BASE)
                w_valid = 1'b0;
        end
    end

    assign w_zero = (r_data == '0);
    assign w_one  = (r_data == LP_W'(1));

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_data     <= '0;
            r_rl       <= '0;
            r_done     <= 1'b0;
            r_load_err <= 1'b0;
        end else begin
            r_done     <= 1'b0;
            r_load_err <= 1'b0;
            if (load) begin
                if (w_valid) begin
                    r_data  <= load_data;
                    r_rl    <= load_data;
                    r_state <= ST_IDLE;
                end else begin
                    r_load_err <= 1'b1;
                end
            end else if (stop) begin
                r_state <= ST_IDLE;
            end else if (start && r_state == ST_IDLE) begin
                if (!w_zero)
                    r_state <= ST_RUN;
            end else if (ce && r_state == ST_RUN) begin
                if (w_one) begin
                    r_done <= 1'b1;
                    if (PARAM_AUTO_RELOAD) begin
                        r_data <= r_rl;
                    end else begin
                        r_data  <= '0;
                        r_state <= ST_IDLE;
                    end
                end else if (w_zero) begin
                    // Unreachable guard: never wrap below zero.
                    r_state <= ST_IDLE;
                end else begin
                    r_data <= w_dec;
                end
            end
        end
    end

    assign data     = r_data;
    assign running  = (r_state == ST_RUN);
    assign done     = r_done;
    assign load_err = r_load_err;

endmodule
